decode_sdiv_59s_20s_40_seq: RTL and testbench
=============================================

Name: decode_sdiv_59s_20s_40_seq

Overview:
Sequential signed divider, the inverse of the decoder's 40s x 20s -> 59 multiplier stage. It recovers a 40-bit signed quotient and a 20-bit signed remainder from a 59-bit signed dividend and a 20-bit signed divisor. It uses a radix-2 restoring algorithm with a start/done handshake and a ce stall input. It is used in the decode datapath wherever a scaled product must be normalised back.

Parameters:
ID, 1, instance identifier; no functional effect.
din0_WIDTH, 59, dividend width, signed.
din1_WIDTH, 20, divisor width, signed; also the remainder width.
dout_WIDTH, 40, quotient width, signed.

Ports:
clk  in  1  clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
ce  in  1  clock enable; when low, all registers hold.
start  in  1  request; sampled only when ready=1 and ce=1.
din0  in  din0_WIDTH  dividend, signed.
din1  in  din1_WIDTH  divisor, signed.
ready  out  1  high in IDLE; block can accept start.
dout_vld  out  1  one-cycle pulse when the result is valid.
dout  out  dout_WIDTH  quotient, signed.
rem  out  din1_WIDTH  remainder, signed.
dbz  out  1  divide-by-zero flag, valid with dout_vld.
ovf  out  1  quotient-saturated flag, valid with dout_vld.

Behaviour:
- Reset values: state=IDLE, ready=1, dout_vld=0, dout=0, rem=0, dbz=0, ovf=0, iteration counter=0.
- Reset during any state aborts the operation. The next cycle is IDLE and no dout_vld is produced.
- ce=0 freezes state, counter, datapath and outputs. A dout_vld pulse in progress is held, not repeated.
- States and transitions:
  - IDLE: on start&ce, latch |din0| and |din1|, latch the sign of each operand and the dividend sign, clear the counter, then go to CALC.
  - CALC: runs exactly din0_WIDTH active cycles. Each cycle: shift the partial remainder (din1_WIDTH+1 bits) left and bring in the next dividend MSB. If partial >= |divisor|, subtract and set the quotient bit to 1; otherwise set it to 0. Counter reaches din0_WIDTH-1, then go to SIGN.
  - SIGN: negate the quotient if the operand signs differ. Negate the remainder if the dividend is negative. Saturate and register the outputs, assert dout_vld, then go to IDLE.
- Latency: start sampled at active edge 0 -> dout_vld high after edge din0_WIDTH+1, i.e. 60 active cycles. dout_vld is high for exactly one active cycle. Outputs hold their value until the next result.
- Throughput: one operation per din0_WIDTH+2 cycles. The cycle after dout_vld has ready=1.
- start while ready=0 is ignored, not queued.
- Semantics are C-style: quotient truncates toward zero; remainder takes the sign of the dividend; |rem| < |din1|.
- Divide-by-zero (din1==0), detected at IDLE latch: dbz=1, ovf=0, rem=din0[din1_WIDTH-1:0]. dout=+(2^39-1) if din0>=0, else -2^39. Latency is unchanged.
- Overflow: if the true quotient is outside [-2^39, 2^39-1], dout saturates to the nearer bound, ovf=1, and rem is still exact. The case din0=-2^58, din1=-1 is included.
- Magnitudes: |din0| is held in din0_WIDTH bits unsigned, so -2^58 is handled exactly. |din1| is held in din1_WIDTH bits.

Decomposition:
- Package decode_div_pkg holds:
  - state enum {IDLE, CALC, SIGN};
  - the default width constants;
  - Q_MAX = 2^39-1 and Q_MIN = -2^39 saturation constants;
  - CNT_W = clog2(din0_WIDTH).
- One sub-module: decode_sdiv_step, the combinational single restoring iteration. It takes partial remainder, next bit and divisor, and returns the new partial and the quotient bit. It is instantiated once in the FSM module.

Test Plan:
- din0=1000, din1=7, start pulse -> ready drops. dout_vld after 60 cycles with dout=142, rem=6, dbz=0, ovf=0.
- Signed quadrants: -1000/7 -> dout=-142, rem=-6. 1000/-7 -> -142, 6. -1000/-7 -> 142, -6.
- din1=0 with din0=-5 -> dout=-2^39, rem=-5, dbz=1. With din0=5 -> dout=2^39-1, rem=5, dbz=1.
- din0=-2^58, din1=-1 -> dout=2^39-1, ovf=1, rem=0. din0=2^45, din1=2 -> dout=2^39-1, ovf=1.
- start re-asserted mid-CALC -> ignored, first result unchanged. Hold ce=0 for 10 cycles mid-CALC -> dout_vld arrives 10 cycles later with the correct value.
- Assert reset at cycle 30 of CALC -> next cycle ready=1, all outputs 0, no dout_vld. A new start of 1000/7 completes correctly.

Source files
------------

// File: rtl/decode_div_pkg.sv
// rtl/decode_div_pkg.sv - shared types and constants for the decode signed divider
package decode_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      SIGN
   } state_t;

   localparam int DIN0_W = 59;
   localparam int DIN1_W = 20;
   localparam int DOUT_W = 40;
   localparam int CNT_W  = $clog2(DIN0_W);

   localparam logic signed [DOUT_W-1:0] Q_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
   localparam logic signed [DOUT_W-1:0] Q_MIN = {1'b1, {(DOUT_W-1){1'b0}}};

endpackage

// File: rtl/decode_sdiv_step.sv
// rtl/decode_sdiv_step.sv - one combinational restoring-division iteration
module decode_sdiv_step #(
   parameter int W = 20
) (
   input  logic [W:0]   part_i,
   input  logic         bit_i,
   input  logic [W-1:0] dvs_i,
   output logic [W:0]   part_o,
   output logic         q_o
);

   logic [W+1:0] shifted;

   always_comb begin
      shifted = {part_i, bit_i};
      q_o     = (shifted >= {2'b00, dvs_i});
      part_o  = q_o ? (W+1)'(shifted - {2'b00, dvs_i}) : shifted[W:0];
   end

endmodule

// File: rtl/decode_sdiv_59s_20s_40_seq.sv
// rtl/decode_sdiv_59s_20s_40_seq.sv - sequential signed restoring divider, 59s / 20s -> 40s quotient, 20s remainder
module decode_sdiv_59s_20s_40_seq
   import decode_div_pkg::*;
#(
   parameter int ID         = 1,
   parameter int din0_WIDTH = DIN0_W,
   parameter int din1_WIDTH = DIN1_W,
   parameter int dout_WIDTH = DOUT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  ready,
   output logic                  dout_vld,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  dbz,
   output logic                  ovf
);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [din0_WIDTH-1:0]   quo_q, quo_d;
   logic [din1_WIDTH:0]     part_q, part_d;
   logic [din1_WIDTH-1:0]   dvs_q, dvs_d;
   logic [din1_WIDTH-1:0]   lo_q, lo_d;
   logic                    qneg_q, qneg_d;
   logic                    rneg_q, rneg_d;
   logic                    zdiv_q, zdiv_d;
   logic [dout_WIDTH-1:0]   dout_q, dout_d;
   logic [din1_WIDTH-1:0]   rem_q, rem_d;
   logic                    vld_q, vld_d;
   logic                    dbz_q, dbz_d;
   logic                    ovf_q, ovf_d;

   logic [din1_WIDTH:0]     step_part;
   logic                    step_q;
   logic                    pos_ovf, neg_ovf;

   // quo_q doubles as the dividend shifter: MSB feeds the step, quotient bits enter at the LSB
   decode_sdiv_step #(.W(din1_WIDTH)) u_step (
      .part_i (part_q),
      .bit_i  (quo_q[din0_WIDTH-1]),
      .dvs_i  (dvs_q),
      .part_o (step_part),
      .q_o    (step_q)
   );

   always_comb begin
      pos_ovf = |quo_q[din0_WIDTH-1:dout_WIDTH-1];
      neg_ovf = (|quo_q[din0_WIDTH-1:dout_WIDTH]) ||
                (quo_q[dout_WIDTH-1] && (|quo_q[dout_WIDTH-2:0]));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      part_d  = part_q;
      dvs_d   = dvs_q;
      lo_d    = lo_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      zdiv_d  = zdiv_q;
      dout_d  = dout_q;
      rem_d   = rem_q;
      vld_d   = vld_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      if (ce) begin
         vld_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  quo_d   = din0[din0_WIDTH-1] ? -din0 : din0;
                  dvs_d   = din1[din1_WIDTH-1] ? -din1 : din1;
                  part_d  = '0;
                  lo_d    = din0[din1_WIDTH-1:0];
                  qneg_d  = din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
                  rneg_d  = din0[din0_WIDTH-1];
                  zdiv_d  = (din1 == '0);
                  cnt_d   = '0;
                  state_d = CALC;
               end
            end
            CALC: begin
               part_d = step_part;
               quo_d  = {quo_q[din0_WIDTH-2:0], step_q};
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(din0_WIDTH - 1)) begin
                  state_d = SIGN;
               end
            end
            SIGN: begin
               vld_d   = 1'b1;
               dbz_d   = zdiv_q;
               state_d = IDLE;
               if (zdiv_q) begin
                  ovf_d  = 1'b0;
                  rem_d  = lo_q;
                  dout_d = rneg_q ? Q_MIN : Q_MAX;
               end else begin
                  rem_d = rneg_q ? din1_WIDTH'(-part_q) : din1_WIDTH'(part_q);
                  if (qneg_q) begin
                     ovf_d  = neg_ovf;
                     dout_d = neg_ovf ? Q_MIN : -quo_q[dout_WIDTH-1:0];
                  end else begin
                     ovf_d  = pos_ovf;
                     dout_d = pos_ovf ? Q_MAX : quo_q[dout_WIDTH-1:0];
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         part_q  <= '0;
         dvs_q   <= '0;
         lo_q    <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         zdiv_q  <= 1'b0;
         dout_q  <= '0;
         rem_q   <= '0;
         vld_q   <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         part_q  <= part_d;
         dvs_q   <= dvs_d;
         lo_q    <= lo_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         zdiv_q  <= zdiv_d;
         dout_q  <= dout_d;
         rem_q   <= rem_d;
         vld_q   <= vld_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ready    = (state_q == IDLE);
   assign dout_vld = vld_q;
   assign dout     = dout_q;
   assign rem      = rem_q;
   assign dbz      = dbz_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_decode_sdiv_59s_20s_40_seq.sv
// tb/tb_decode_sdiv_59s_20s_40_seq.sv - self-checking bench for the sequential signed divider
module tb_decode_sdiv_59s_20s_40_seq;

   localparam longint QMAX = 64'sd549755813887;
   localparam longint QMIN = -64'sd549755813888;
   localparam int     LAT  = 60;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic        start;
   logic [58:0] din0;
   logic [19:0] din1;
   logic        ready;
   logic        dout_vld;
   logic [39:0] dout;
   logic [19:0] rem;
   logic        dbz;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   typedef struct {
      longint a;
      longint b;
      longint q;
      longint r;
      bit     z;
      bit     o;
   } vec_t;

   vec_t tbl[$];

   decode_sdiv_59s_20s_40_seq dut (
      .clk      (clk),
      .reset    (reset),
      .ce       (ce),
      .start    (start),
      .din0     (din0),
      .din1     (din1),
      .ready    (ready),
      .dout_vld (dout_vld),
      .dout     (dout),
      .rem      (rem),
      .dbz      (dbz),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // C-style truncating division with saturation, straight from the arithmetic rules
   function automatic void model(input longint a, input longint b, output longint q,
                                 output longint r, output bit z, output bit o);
      logic [19:0] lo;
      if (b == 0) begin
         lo = a[19:0];
         z  = 1'b1;
         o  = 1'b0;
         q  = (a < 0) ? QMIN : QMAX;
         r  = longint'($signed(lo));
      end else begin
         z = 1'b0;
         q = a / b;
         r = a % b;
         o = (q > QMAX) || (q < QMIN);
         if (q > QMAX) q = QMAX;
         if (q < QMIN) q = QMIN;
      end
   endfunction

   task automatic launch(input longint a, input longint b);
      din0  = a[58:0];
      din1  = b[19:0];
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_vld(output int lat);
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         lat++;
         if (dout_vld) return;
      end
      lat = -1;
   endtask

   task automatic chk_result(input string name, input longint q, input longint r, input bit z, input bit o);
      chk({name, ".dout"}, $signed(dout), q);
      chk({name, ".rem"}, $signed(rem), r);
      chk({name, ".dbz"}, dbz, z);
      chk({name, ".ovf"}, ovf, o);
   endtask

   task automatic run_check(input string name, input longint a, input longint b,
                            input longint q, input longint r, input bit z, input bit o);
      int lat;
      launch(a, b);
      chk({name, ".ready_low"}, ready, 0);
      wait_vld(lat);
      chk({name, ".latency"}, lat, LAT);
      chk_result(name, q, r, z, o);
   endtask

   initial begin
      int     lat;
      int     nvld;
      longint a, b, q, r;
      bit     z, o;
      logic signed [58:0] a59;
      logic signed [19:0] b20;

      reset = 1'b1;
      ce    = 1'b1;
      start = 1'b0;
      din0  = '0;
      din1  = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("reset.ready", ready, 1);
      chk("reset.vld", dout_vld, 0);
      chk_result("reset", 0, 0, 0, 0);

      tbl.push_back('{1000, 7, 142, 6, 0, 0});
      tbl.push_back('{-1000, 7, -142, -6, 0, 0});
      tbl.push_back('{1000, -7, -142, 6, 0, 0});
      tbl.push_back('{-1000, -7, 142, -6, 0, 0});
      tbl.push_back('{-5, 0, QMIN, -5, 1, 0});
      tbl.push_back('{5, 0, QMAX, 5, 1, 0});
      tbl.push_back('{-64'sd288230376151711744, -1, QMAX, 0, 0, 1});
      tbl.push_back('{64'sd35184372088832, 2, QMAX, 0, 0, 1});
      tbl.push_back('{-64'sd1649267441664, 3, QMIN, 0, 0, 0});
      tbl.push_back('{64'sd1649267441664, 3, QMAX, 0, 0, 1});
      tbl.push_back('{QMAX, 1, QMAX, 0, 0, 0});
      tbl.push_back('{64'sd288230376151711743, -524288, -64'sd549755813887, 524287, 0, 0});
      tbl.push_back('{0, 5, 0, 0, 0, 0});
      tbl.push_back('{-64'sd288230376151711744, -524288, QMAX, 0, 0, 1});

      foreach (tbl[i]) begin
         run_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].o);
         tick();
         chk($sformatf("vec%0d.pulse", i), dout_vld, 0);
      end

      for (int i = 0; i < 40; i++) begin
         a59 = {$urandom(), $urandom()};
         a59 = a59 >>> $urandom_range(0, 58);
         b20 = $urandom();
         b20 = b20 >>> $urandom_range(0, 19);
         if ($urandom_range(0, 9) == 0) b20 = '0;
         a = a59;
         b = b20;
         model(a, b, q, r, z, o);
         run_check($sformatf("rand%0d", i), a, b, q, r, z, o);
      end

      // start raised mid-calculation must be dropped, not queued
      launch(1000, 7);
      repeat (20) tick();
      din0  = 59'd5;
      din1  = 20'd1;
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      wait_vld(lat);
      chk("midstart.latency", lat, LAT - 23);
      chk_result("midstart", 142, 6, 0, 0);
      nvld = 0;
      repeat (70) begin
         tick();
         if (dout_vld) nvld++;
      end
      chk("midstart.no_extra", nvld, 0);

      // ce low for 10 cycles stretches latency by exactly 10
      launch(-1000, 7);
      repeat (20) tick();
      ce = 1'b0;
      repeat (10) tick();
      chk("cehold.ready", ready, 0);
      ce = 1'b1;
      wait_vld(lat);
      chk("cehold.latency", 30 + lat, LAT + 10);
      chk_result("cehold", -142, -6, 0, 0);

      // a pulse already on the output is frozen by ce=0 and ends after one active cycle
      ce = 1'b0;
      repeat (3) tick();
      chk("vldhold.held", dout_vld, 1);
      ce = 1'b1;
      tick();
      chk("vldhold.cleared", dout_vld, 0);
      chk("vldhold.ready", ready, 1);
      chk_result("vldhold", -142, -6, 0, 0);

      // reset in the middle of a calculation
      launch(1000, -7);
      repeat (30) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort.ready", ready, 1);
      chk("abort.vld", dout_vld, 0);
      chk_result("abort", 0, 0, 0, 0);
      nvld = 0;
      repeat (70) begin
         tick();
         if (dout_vld) nvld++;
      end
      chk("abort.no_vld", nvld, 0);
      run_check("after_abort", 1000, 7, 142, 6, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
